// File: rtl/latch_bank_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : latch_bank_ctrl_if
// Purpose  : Requester-side bundle for latch_bank_ctrl. Carries the packed
//            per-requester write requests and the one-hot completion pulses.
// Signals  : req      [NREQ]         write request level, one bit per requester
//            req_addr [NREQ*ADDR_W]  requester i at [i*ADDR_W +: ADDR_W]
//            req_data [NREQ*DATA_W]  requester i at [i*DATA_W +: DATA_W]
//            ack      [NREQ]         one-cycle completion pulse, one-hot
// Modports : master = requester side, slave = controller side
// Revision : 1.0 - initial release
// ============================================================================
interface latch_bank_ctrl_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
);
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        ack;

  modport master (output req, output req_addr, output req_data, input ack);
  modport slave  (input req, input req_addr, input req_data, output ack);
endinterface
`default_nettype wire

// File: rtl/latch_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : latch_bank_ctrl
// Purpose  : Round-robin arbiter and write sequencer for a bank of NLATCH
//            transparent D-latches shared by NREQ requesters. Each write is
//            a SETUP / OPEN (EN_CYCLES) / HOLD sequence so the shared data
//            bus is stable before, during and after the enable pulse.
// Ports    : clk     in   system clock, rising edge
//            rst_n   in   asynchronous active-low reset
//            bus     slv  requester bundle (req, req_addr, req_data, ack)
//            lat_d   out  [DATA_W] shared latch data bus
//            lat_en  out  [NLATCH] per-latch enable, at most one bit high
//            busy    out  high whenever a write is in flight
//            err     out  (only with LATCH_BANK_CTRL_ERR_EN) pulses with ack
//                         when the write targeted an address >= NLATCH
// Options  : `define LATCH_BANK_CTRL_ERR_EN to add the err output.
// Revision : 1.0 - initial release
// ============================================================================
module latch_bank_ctrl #(
  parameter int NREQ      = 2,
  parameter int NLATCH    = 4,
  parameter int ADDR_W    = 2,
  parameter int DATA_W    = 8,
  parameter int EN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  latch_bank_ctrl_if.slave   bus,
  output logic [DATA_W-1:0]  lat_d,
  output logic [NLATCH-1:0]  lat_en,
  output logic               busy
`ifdef LATCH_BANK_CTRL_ERR_EN
  ,
  output logic               err
`endif
);

  localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW1 = GW + 1;
  localparam int AW1 = ADDR_W + 1;
  localparam int CW  = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

  localparam logic [GW:0]     C_NREQ      = GW1'(NREQ);
  localparam logic [GW-1:0]   C_LAST_REQ  = GW'(NREQ - 1);
  localparam logic [ADDR_W:0] C_NLATCH    = AW1'(NLATCH);
  localparam logic [CW-1:0]   C_OPEN_LAST = CW'(EN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_OPEN  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t              r_state;
  logic [GW-1:0]       r_rr_ptr;
  logic [GW-1:0]       r_grant;
  logic [ADDR_W-1:0]   r_addr;
  logic [CW-1:0]       r_cnt;
  logic [DATA_W-1:0]   r_lat_d;
  logic [NLATCH-1:0]   r_lat_en;
  logic [NREQ-1:0]     r_ack;
  logic                r_busy;
`ifdef LATCH_BANK_CTRL_ERR_EN
  logic                r_err;
`endif

  logic [GW:0]         w_cand;
  logic [GW-1:0]       w_gnt_idx;
  logic                w_gnt_vld;
  logic                w_addr_ok;

  // Round-robin pick: scan from the highest offset down so the requester
  // closest to r_rr_ptr is the last one written and therefore wins.
  always_comb begin
    w_cand    = '0;
    w_gnt_idx = '0;
    w_gnt_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = {1'b0, r_rr_ptr} + GW1'(k);
      if (w_cand >= C_NREQ) begin
        w_cand = w_cand - C_NREQ;
      end
      if (bus.req[w_cand[GW-1:0]]) begin
        w_gnt_idx = w_cand[GW-1:0];
        w_gnt_vld = 1'b1;
      end
    end
  end

  // Out-of-range targets still run the full sequence but never open a latch.
  assign w_addr_ok = ({1'b0, r_addr} < C_NLATCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_lat_d  <= '0;
      r_lat_en <= '0;
      r_ack    <= '0;
      r_busy   <= 1'b0;
`ifdef LATCH_BANK_CTRL_ERR_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_ack <= '0;
`ifdef LATCH_BANK_CTRL_ERR_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_state  <= S_SETUP;
            r_grant  <= w_gnt_idx;
            r_addr   <= bus.req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
            // The data bus only ever moves here, while every enable is low.
            r_lat_d  <= bus.req_data[w_gnt_idx*DATA_W +: DATA_W];
            r_rr_ptr <= (w_gnt_idx == C_LAST_REQ) ? '0 : w_gnt_idx + 1'b1;
            r_busy   <= 1'b1;
          end
        end
        S_SETUP: begin
          r_state  <= S_OPEN;
          r_cnt    <= C_OPEN_LAST;
          r_lat_en <= w_addr_ok ? (NLATCH'(1) << r_addr) : '0;
        end
        S_OPEN: begin
          if (r_cnt == '0) begin
            r_state  <= S_HOLD;
            r_lat_en <= '0;
            r_ack    <= NREQ'(1) << r_grant;
`ifdef LATCH_BANK_CTRL_ERR_EN
            r_err    <= ~w_addr_ok;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_lat_en <= '0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign lat_d   = r_lat_d;
  assign lat_en  = r_lat_en;
  assign busy    = r_busy;
  assign bus.ack = r_ack;
`ifdef LATCH_BANK_CTRL_ERR_EN
  assign err     = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_latch_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_latch_bank_ctrl
// Purpose  : Self-checking bench for latch_bank_ctrl. A transaction-timeline
//            model (cycles elapsed since grant) predicts every output each
//            cycle; directed scenarios pin literal values on top of it.
//            Build with LATCH_BANK_CTRL_ERR_EN defined to also check err.
// Revision : 1.0 - initial release
// ============================================================================
module tb_latch_bank_ctrl;
  localparam int NREQ      = 3;
  localparam int NLATCH    = 3;
  localparam int ADDR_W    = 2;
  localparam int DATA_W    = 8;
  localparam int EN_CYCLES = 2;
  localparam int TXN       = EN_CYCLES + 3;
`ifdef LATCH_BANK_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  latch_bank_ctrl_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [DATA_W-1:0] lat_d;
  logic [NLATCH-1:0] lat_en;
  logic              busy;
  logic              err;
`ifndef LATCH_BANK_CTRL_ERR_EN
  assign err = 1'b0;
`endif

  latch_bank_ctrl #(
    .NREQ(NREQ), .NLATCH(NLATCH), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .EN_CYCLES(EN_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .lat_d(lat_d),
    .lat_en(lat_en),
    .busy(busy)
`ifdef LATCH_BANK_CTRL_ERR_EN
    ,
    .err(err)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_t = cycles since the grant edge (0 = no write in flight).
  int                m_t, m_g, m_rr, m_pick;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;

  function automatic int pick(input logic [NREQ-1:0] r, input int rr);
    for (int k = 0; k < NREQ; k++)
      if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  always_comb m_pick = pick(bus.req, m_rr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; m_g <= 0; m_rr <= 0; m_addr <= '0; m_data <= '0;
    end else if (m_t == 0) begin
      if (m_pick >= 0) begin
        m_t    <= 1;
        m_g    <= m_pick;
        m_rr   <= (m_pick + 1) % NREQ;
        m_addr <= bus.req_addr[m_pick*ADDR_W +: ADDR_W];
        m_data <= bus.req_data[m_pick*DATA_W +: DATA_W];
      end
    end else if (m_t == EN_CYCLES + 2) begin
      m_t <= 0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  logic              exp_busy, exp_err;
  logic [DATA_W-1:0] exp_lat_d;
  logic [NLATCH-1:0] exp_lat_en;
  logic [NREQ-1:0]   exp_ack;

  always_comb begin
    exp_busy   = (m_t != 0);
    exp_lat_d  = m_data;
    exp_lat_en = '0;
    if (m_t >= 2 && m_t <= EN_CYCLES + 1 && int'(m_addr) < NLATCH)
      exp_lat_en = NLATCH'(1) << m_addr;
    exp_ack    = (m_t == EN_CYCLES + 2) ? (NREQ'(1) << m_g) : '0;
    exp_err    = ERR_EN && (m_t == EN_CYCLES + 2) && (int'(m_addr) >= NLATCH);
  end

  // One compare process, every cycle, on the falling edge.
  always @(negedge clk) begin
    chk("m_lat_d",  32'(lat_d),  32'(exp_lat_d));
    chk("m_lat_en", 32'(lat_en), 32'(exp_lat_en));
    chk("m_ack",    32'(bus.ack), 32'(exp_ack));
    chk("m_busy",   32'(busy),   32'(exp_busy));
    chk("m_err",    32'(err),    32'(exp_err));
    chk("en_onehot0",  32'($countones(lat_en) <= 1), 32'd1);
    chk("ack_onehot0", 32'($countones(bus.ack) <= 1), 32'd1);
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input int i, input logic r, input int a, input int d);
    bus.req[i] = r;
    bus.req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
    bus.req_data[i*DATA_W +: DATA_W] = DATA_W'(d);
  endtask

  task automatic do_reset();
    bus.req = '0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bus.req = '0; bus.req_addr = '0; bus.req_data = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_lat_en", 32'(lat_en), 0);
    chk("rst_lat_d", 32'(lat_d), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;

    // Single write: requester 0, addr 2, data A5
    @(negedge clk);
    set_req(0, 1'b1, 2, 8'hA5);
    @(negedge clk);                                  // cycle 1: SETUP
    chk("sw_lat_d_c1", 32'(lat_d), 32'hA5);
    chk("sw_en_c1", 32'(lat_en), 0);
    bus.req_data[7:0] = 8'h5A;                       // captured value must not follow
    @(negedge clk);                                  // cycle 2
    chk("sw_en_c2", 32'(lat_en), 32'b100);
    chk("model_en_c2", 32'(exp_lat_en), 32'b100);
    @(negedge clk);                                  // cycle 3
    chk("sw_en_c3", 32'(lat_en), 32'b100);
    chk("sw_lat_d_c3", 32'(lat_d), 32'hA5);
    @(negedge clk);                                  // cycle 4: HOLD
    chk("sw_ack_c4", 32'(bus.ack), 32'b001);
    chk("model_ack_c4", 32'(exp_ack), 32'b001);
    chk("sw_en_c4", 32'(lat_en), 0);
    bus.req[0] = 1'b0;
    @(negedge clk);                                  // cycle 5: IDLE
    chk("sw_busy_c5", 32'(busy), 0);

    // Contention: requesters 0 and 1 together, rr_ptr = 0
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 0, 8'h11);
    set_req(1, 1'b1, 1, 8'h22);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 2) chk("ct_en_c2", 32'(lat_en), 32'b001);
      if (c == 4) begin chk("ct_ack_c4", 32'(bus.ack), 32'b001); bus.req[0] = 1'b0; end
      if (c == 6) chk("ct_lat_d_c6", 32'(lat_d), 32'h22);
      if (c == 7) chk("ct_en_c7", 32'(lat_en), 32'b010);
      if (c == 9) begin chk("ct_ack_c9", 32'(bus.ack), 32'b010); bus.req[1] = 1'b0; end
    end

    // Fairness: two requesters held high continuously
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 0, 8'h01);
    set_req(1, 1'b1, 1, 8'h02);
    for (int n = 0; n < 4; n++) begin
      for (int w = 0; w < 2*TXN && bus.ack == '0; w++) @(negedge clk);
      chk("fair_ack", 32'(bus.ack), (n % 2 == 0) ? 32'b001 : 32'b010);
      @(negedge clk);
    end
    bus.req = '0;

    // Out-of-range: requester 2, addr 3 with NLATCH = 3
    do_reset();
    @(negedge clk);
    set_req(2, 1'b1, 3, 8'hC3);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) chk("oor_lat_d", 32'(lat_d), 32'hC3);
      if (c == 2 || c == 3) chk("oor_en", 32'(lat_en), 0);
      if (c == 4) begin
        chk("oor_ack", 32'(bus.ack), 32'b100);
        chk("oor_err", 32'(err), 32'(ERR_EN));
        chk("model_err", 32'(exp_err), 32'(ERR_EN));
        bus.req[2] = 1'b0;
      end
    end

    // Reset in OPEN: enable must fall before the next clock edge
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 1, 8'h77);
    repeat (2) @(negedge clk);
    chk("ro_en_open", 32'(lat_en), 32'b010);
    #2 rst_n = 1'b0;
    #1;
    chk("ro_en_async", 32'(lat_en), 0);
    chk("ro_busy_async", 32'(busy), 0);
    @(negedge clk);
    chk("ro_no_ack", 32'(bus.ack), 0);
    set_req(1, 1'b1, 2, 8'h88);
    rst_n = 1'b1;
    for (int w = 0; w < 2*TXN && bus.ack == '0; w++) @(negedge clk);
    chk("ro_rr_restart", 32'(bus.ack), 32'b001);
    @(negedge clk);
    bus.req = '0;

    // Randomized traffic against the model
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req[i]) begin
          if (bus.ack[i]) begin
            if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
            else set_req(i, 1'b1, $urandom_range(0, 3), $urandom);
          end
        end else if ($urandom_range(0, 3) == 0) begin
          set_req(i, 1'b1, $urandom_range(0, 3), $urandom);
        end else begin
          set_req(i, 1'b0, $urandom_range(0, 3), $urandom);
        end
      end
      if ($urandom_range(0, 599) == 0) begin
        #($urandom_range(1, 4)) rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    bus.req = '0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
